// File: rtl/seq_sched_if.sv
// Scheduler <-> requesters/consumer bundle: request levels, grant and the beat stream.
// SEQ_SCHED_ABORT_EN adds the abort input.
interface seq_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_data;
    logic [IDW-1:0]  out_id;
    logic            out_last;
    logic            busy;
`ifdef SEQ_SCHED_ABORT_EN
    logic            abort;

    modport master (input req, out_ready, abort,
                    output grant, out_valid, out_data, out_id, out_last, busy);
    modport slave  (output req, out_ready, abort,
                    input grant, out_valid, out_data, out_id, out_last, busy);
`else
    modport master (input req, out_ready,
                    output grant, out_valid, out_data, out_id, out_last, busy);
    modport slave  (output req, out_ready,
                    input grant, out_valid, out_data, out_id, out_last, busy);
`endif
endinterface

// File: rtl/seq_sched.sv
// Round-robin scheduler sharing one 4-bit even-sequence engine among NREQ requesters.
// Optional early burst termination is enabled with SEQ_SCHED_ABORT_EN.
module seq_sched #(
    parameter int NREQ  = 4,
    parameter int BURST = 4,
    parameter int IDW   = 2
) (
    input logic         clk,
    input logic         reset,
    seq_sched_if.master bus
);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t               state, state_nxt;
    logic [NREQ-1:0][2:0] saved_idx;
    logic [2:0]           cur_idx, idx_inc, wb_idx, load_idx;
    logic [CW-1:0]        beat_cnt;
    logic [IDW-1:0]       rr_ptr, owner, win_idx, ptr_nxt, cand;
    logic                 win_found, xfer, last, abort_hit, end_burst, start;

`ifdef SEQ_SCHED_ABORT_EN
    assign abort_hit = (state == RUN) && bus.abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign xfer      = (state == RUN) && bus.out_ready;
    assign last      = (beat_cnt == CW'(BURST - 1));
    assign idx_inc   = cur_idx + 3'd1;
    // a beat accepted in the abort cycle counts as delivered
    assign wb_idx    = xfer ? idx_inc : cur_idx;
    assign end_burst = (xfer && last) || abort_hit;
    assign start     = ((state == IDLE) || end_burst) && win_found;
    // same requester re-granted back-to-back must see the index being written back
    assign load_idx  = (end_burst && (win_idx == owner)) ? wb_idx : saved_idx[win_idx];

    // first set request at or after rr_ptr, wrapping upward
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(rr_ptr) + k) % NREQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        ptr_nxt = IDW'((int'(win_idx) + 1) % NREQ);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = RUN;
            RUN:     if (end_burst && !win_found) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.grant     = '0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_id    = '0;
        bus.out_last  = 1'b0;
        bus.busy      = 1'b0;
        if (state == RUN) begin
            bus.grant     = NREQ'(1) << owner;
            bus.out_valid = 1'b1;
            bus.out_data  = {cur_idx, 1'b0};
            bus.out_id    = owner;
            bus.out_last  = last;
            bus.busy      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            saved_idx <= '0;
            cur_idx   <= '0;
            beat_cnt  <= '0;
            rr_ptr    <= '0;
            owner     <= '0;
        end else begin
            if (end_burst) saved_idx[owner] <= wb_idx;
            if (start) begin
                owner    <= win_idx;
                rr_ptr   <= ptr_nxt;
                beat_cnt <= '0;
                cur_idx  <= load_idx;
            end else if (xfer) begin
                cur_idx  <= idx_inc;
                beat_cnt <= beat_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_seq_sched.sv
// Scoreboard bench for seq_sched (NREQ=4, BURST=4): expected beats queued at stimulus time.
module tb_seq_sched;
    typedef struct {
        logic [3:0] data;
        logic [1:0] id;
        logic       last;
    } beat_t;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    int    n_chk = 0;
    int    n_err = 0;
    int    cyc_a, cyc_b;
    beat_t sb[$];
    beat_t exp_b;

    seq_sched_if #(.NREQ(4), .IDW(2)) bus ();

    seq_sched #(.NREQ(4), .BURST(4), .IDW(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input int id, input int data, input bit last);
        beat_t b;
        b.data = 4'(data);
        b.id   = 2'(id);
        b.last = last;
        sb.push_back(b);
    endtask

    task automatic push_burst(input int id, input int first);
        for (int i = 0; i < 4; i++) push_beat(id, (first + 2 * i) % 16, i == 3);
    endtask

    // wait until at most n beats remain outstanding; returns edges waited
    task automatic wait_q(input int n, output int cyc);
        cyc = 0;
        while (sb.size() > n && cyc < 200) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        if (sb.size() > n) begin
            chk("timeout", 32'(sb.size()), 32'(n));
            sb.delete();
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 0);
        chk({tag, "_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_grant"}, 32'(bus.grant), 0);
        chk({tag, "_data"},  32'(bus.out_data), 0);
        chk({tag, "_id"},    32'(bus.out_id), 0);
        chk({tag, "_last"},  32'(bus.out_last), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'(bus.out_data), 32'hdead);
            end else begin
                exp_b = sb.pop_front();
                chk("data",  32'(bus.out_data), 32'(exp_b.data));
                chk("id",    32'(bus.out_id),   32'(exp_b.id));
                chk("last",  32'(bus.out_last), 32'(exp_b.last));
                chk("grant", 32'(bus.grant),    32'(4'b0001 << exp_b.id));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req       = '0;
        bus.out_ready = 1'b1;
`ifdef SEQ_SCHED_ABORT_EN
        bus.abort     = 1'b0;
`endif
        tick();
        tick();
        chk_idle("reset");
        reset = 1'b0;

        // single requester: three bursts, index wraps 14 -> 0
        bus.req = 4'b0001;
        push_burst(0, 0);
        push_burst(0, 8);
        push_burst(0, 0);
        wait_q(3, cyc_a);
        bus.req = '0;
        wait_q(0, cyc_b);
        chk("s1_cycles", 32'(cyc_a + cyc_b), 13);
        chk_idle("s1_end");

        // two requesters alternate with zero-gap handover, own positions kept
        do_reset();
        bus.req = 4'b0101;
        push_burst(0, 0);
        push_burst(2, 0);
        push_burst(0, 8);
        wait_q(3, cyc_a);
        bus.req = '0;
        wait_q(0, cyc_b);
        chk("s2_cycles", 32'(cyc_a + cyc_b), 13);
        chk_idle("s2_end");

        // backpressure on beat 2 of requester 1
        do_reset();
        bus.req = 4'b0010;
        push_burst(1, 0);
        wait_q(2, cyc_a);
        bus.out_ready = 1'b0;
        bus.req = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_data",  32'(bus.out_data), 4);
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_grant", 32'(bus.grant), 32'b0010);
        end
        bus.out_ready = 1'b1;
        wait_q(0, cyc_a);
        chk_idle("s3_end");

        // one-cycle pulse still yields a full burst continuing from saved position
        bus.req = 4'b0010;
        tick();
        bus.req = '0;
        push_burst(1, 8);
        wait_q(0, cyc_a);
        chk_idle("s4_end");
        tick();
        chk("s4_stay_idle", 32'(bus.busy), 0);

        // reset during beat 3 discards the burst and clears saved indices
        bus.req = 4'b0001;
        push_beat(0, 0, 0);
        push_beat(0, 2, 0);
        push_beat(0, 4, 0);
        wait_q(0, cyc_a);
        chk("s5_beat3", 32'(bus.out_data), 6);
        reset = 1'b1;
        bus.req = '0;
        tick();
        chk_idle("s5_rst");
        reset = 1'b0;
        tick();
        bus.req = 4'b0001;
        push_burst(0, 0);
        wait_q(3, cyc_a);
        bus.req = '0;
        wait_q(0, cyc_a);
        chk_idle("s5_end");

`ifdef SEQ_SCHED_ABORT_EN
        // abort with beat "2" accepted: next grant resumes at 4
        do_reset();
        bus.req = 4'b0001;
        push_beat(0, 0, 0);
        push_beat(0, 2, 0);
        wait_q(1, cyc_a);
        bus.abort = 1'b1;
        bus.req = '0;
        tick();
        bus.abort = 1'b0;
        chk_idle("ab_end");
        bus.req = 4'b0001;
        push_burst(0, 4);
        wait_q(3, cyc_a);
        bus.req = '0;
        wait_q(0, cyc_a);
        chk_idle("ab_resume_end");
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
